// File: rtl/mac_ctrl_pkg.sv
// Shared types and helpers for the MAC sequencing controller.
package mac_ctrl_pkg;

  // Controller states, explicitly encoded on 3 bits.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Number of bits needed to hold any value from 0 to max_len inclusive.
  function automatic int calc_len_w(input int max_len);
    int w;
    w = 1;
    while ((2 ** w) < (max_len + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the MAC accumulator: clears the MAC, streams len operand
// pairs into it through a valid/ready handshake, then captures the
// accumulated sum and offers it on a valid/ready result port.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 256,
  parameter int LEN_W      = calc_len_w(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    abort,
  output logic                    busy,
  input  logic                    ab_valid,
  output logic                    ab_ready,
  input  logic [DATA_WIDTH-1:0]   a_data,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_V     = LEN_W'(1);

  state_e                  state_r;
  state_e                  state_next_s;
  logic [LEN_W-1:0]        count_r;
  logic [LEN_W-1:0]        count_next_s;
  logic [LEN_W-1:0]        len_q_r;
  logic [LEN_W-1:0]        len_q_next_s;
  logic [3*DATA_WIDTH-1:0] res_data_r;
  logic [3*DATA_WIDTH-1:0] res_data_next_s;
  logic [LEN_W-1:0]        len_clamp_s;

  // State-decoded outputs are registered from the next state so they are
  // glitch-free flops; only the handshake gating stays combinational.
  logic busy_r;
  logic mac_clr_r;
  logic res_valid_r;
  logic accum_r;

  assign len_clamp_s = (len > MAX_LEN_V) ? MAX_LEN_V : len;

  // An abort in the same cycle must refuse the pair, so ready is gated here.
  assign ab_ready  = accum_r & ~abort;
  assign mac_en    = ab_ready & ab_valid;
  assign mac_a     = a_data;
  assign mac_b     = b_data;
  assign busy      = busy_r;
  assign mac_clr   = mac_clr_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;

  // Next-state, job-length latch, element counter and result capture.
  always_comb begin
    state_next_s    = state_r;
    count_next_s    = count_r;
    len_q_next_s    = len_q_r;
    res_data_next_s = res_data_r;
    if (abort) begin
      state_next_s = IDLE;
      count_next_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            len_q_next_s = len_clamp_s;
            state_next_s = CLEAR;
          end else begin
            state_next_s = IDLE;
          end
        end
        CLEAR: begin
          if (len_q_r == '0) begin
            state_next_s = CAPT;
          end else begin
            state_next_s = ACCUM;
          end
        end
        ACCUM: begin
          if (mac_en) begin
            count_next_s = count_r + ONE_V;
            if (count_r == (len_q_r - ONE_V)) begin
              state_next_s = CAPT;
            end else begin
              state_next_s = ACCUM;
            end
          end else begin
            state_next_s = ACCUM;
          end
        end
        CAPT: begin
          // mac_cout already includes the final accumulate from the last edge.
          res_data_next_s = mac_cout;
          count_next_s    = '0;
          state_next_s    = DONE;
        end
        DONE: begin
          if (res_ready) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end
        default: begin
          state_next_s = IDLE;
          count_next_s = '0;
        end
      endcase
    end
  end

  // State, datapath registers and registered state-decoded outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= '0;
      len_q_r     <= '0;
      res_data_r  <= '0;
      busy_r      <= 1'b0;
      mac_clr_r   <= 1'b0;
      res_valid_r <= 1'b0;
      accum_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      len_q_r     <= len_q_next_s;
      res_data_r  <= res_data_next_s;
      busy_r      <= (state_next_s != IDLE);
      mac_clr_r   <= (state_next_s == CLEAR);
      res_valid_r <= (state_next_s == DONE);
      accum_r     <= (state_next_s == ACCUM);
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural MAC attached.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  len;
  logic        abort;
  logic        busy;
  logic        ab_valid;
  logic        ab_ready;
  logic [7:0]  a_data;
  logic [7:0]  b_data;
  logic        mac_en;
  logic        mac_clr;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [23:0] mac_cout;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] pa [300];
  logic [7:0] pb [300];

  typedef struct {
    int          jlen;
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic [23:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t tbl [5];

  mac_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .ab_valid(ab_valid), .ab_ready(ab_ready),
    .a_data(a_data), .b_data(b_data), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: clear wins over enable, registered accumulator.
  logic [23:0] mac_acc = 24'd0;
  always_ff @(posedge clk) begin
    if (mac_clr) mac_acc <= 24'd0;
    else if (mac_en) mac_acc <= mac_acc + 24'(mac_a) * 24'(mac_b);
  end
  assign mac_cout = mac_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product of the first min(n, 256) offered pairs.
  function automatic logic [23:0] ref_dot(input int n);
    int m;
    longint s;
    m = (n > 256) ? 256 : n;
    s = 0;
    for (int i = 0; i < m; i++) s += longint'(pa[i]) * longint'(pb[i]);
    return s[23:0];
  endfunction

  // Runs one job from IDLE; vmode 0 = valid always, 1 = toggling, 2 = random.
  task automatic run_job(input string name, input int jlen, input int vmode,
                         input int stall, input logic [23:0] exp, input int exp_lat);
    int idx = 0, edges = 0, clr = 0, en = 0, hs = 0, bad_en = 0, pt_bad = 0;
    int exp_hs;
    bit got = 1'b0;
    bit tog = 1'b1;
    bit hs_now;
    exp_hs = (jlen > 256) ? 256 : jlen;
    abort = 1'b0;
    res_ready = (stall == 0);
    ab_valid = 1'b0;
    start = 1'b1;
    len = 9'(jlen);
    tick();
    edges = 1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      case (vmode)
        0: ab_valid = 1'b1;
        1: begin ab_valid = tog; tog = ~tog; end
        default: ab_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (stall > 0) start = 1'($urandom_range(0, 1));
      a_data = pa[idx < 299 ? idx : 299];
      b_data = pb[idx < 299 ? idx : 299];
      #1;
      if (mac_clr) clr++;
      if (mac_en) en++;
      if (mac_en && !ab_valid) bad_en++;
      if (mac_a !== a_data || mac_b !== b_data) pt_bad++;
      hs_now = ab_valid && ab_ready;
      if (hs_now) hs++;
      @(posedge clk);
      edges++;
      if (hs_now) idx++;
      #1;
    end
    ab_valid = 1'b0;
    chk({name, " result_seen"}, 64'(got), 64'd1);
    chk({name, " res_data"}, 64'(res_data), 64'(exp));
    if (exp_lat >= 0) chk({name, " latency"}, 64'(edges), 64'(exp_lat));
    chk({name, " mac_clr_pulses"}, 64'(clr), 64'd1);
    chk({name, " mac_en_cycles"}, 64'(en), 64'(exp_hs));
    chk({name, " handshakes"}, 64'(hs), 64'(exp_hs));
    chk({name, " en_without_valid"}, 64'(bad_en), 64'd0);
    chk({name, " operand_passthru"}, 64'(pt_bad), 64'd0);
    for (int s = 0; s < stall; s++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      chk({name, " stall_valid"}, 64'(res_valid), 64'd1);
      chk({name, " stall_data"}, 64'(res_data), 64'(exp));
    end
    // A start coinciding with the result handshake must not be sampled.
    start = (stall > 0);
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    chk({name, " idle_busy"}, 64'(busy), 64'd0);
    chk({name, " idle_res_valid"}, 64'(res_valid), 64'd0);
  endtask

  // Issues a job and stops after n_hs accepted pairs, leaving it in ACCUM.
  task automatic partial_job(input int jlen, input int n_hs);
    int hs = 0;
    start = 1'b1;
    len = 9'(jlen);
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && hs < n_hs; cyc++) begin
      ab_valid = 1'b1;
      a_data = pa[hs];
      b_data = pb[hs];
      #1;
      if (ab_ready) hs++;
      tick();
    end
    chk("partial_handshakes", 64'(hs), 64'(n_hs));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 9'd0; abort = 1'b0;
    ab_valid = 1'b0; a_data = 8'd0; b_data = 8'd0; res_ready = 1'b1;
    tbl[0] = '{4, '{8'd1, 8'd3, 8'd5, 8'd7}, '{8'd2, 8'd4, 8'd6, 8'd8}, 24'd100, 7};
    tbl[1] = '{3, '{8'd255, 8'd255, 8'd255, 8'd0}, '{8'd255, 8'd255, 8'd255, 8'd0}, 24'd195075, 6};
    tbl[2] = '{0, '{8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0, 8'd0}, 24'd0, 3};
    tbl[3] = '{1, '{8'd9, 8'd0, 8'd0, 8'd0}, '{8'd9, 8'd0, 8'd0, 8'd0}, 24'd81, 4};
    tbl[4] = '{2, '{8'd2, 8'd4, 8'd0, 8'd0}, '{8'd3, 8'd5, 8'd0, 8'd0}, 24'd26, 5};

    repeat (2) tick();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ab_ready", 64'(ab_ready), 64'd0);
    chk("rst mac_en", 64'(mac_en), 64'd0);
    chk("rst mac_clr", 64'(mac_clr), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven jobs with ab_valid held high.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        pa[k] = tbl[i].a[k];
        pb[k] = tbl[i].b[k];
      end
      run_job($sformatf("tbl%0d", i), tbl[i].jlen, 0, 0, tbl[i].exp_res, tbl[i].exp_lat);
    end

    // Saturated operands with ab_valid toggling.
    for (int k = 0; k < 3; k++) begin pa[k] = 8'd255; pb[k] = 8'd255; end
    run_job("toggle", 3, 1, 0, 24'd195075, -1);

    // Over-long job is clamped to 256 elements.
    for (int k = 0; k < 300; k++) begin
      pa[k] = 8'($urandom);
      pb[k] = 8'($urandom);
    end
    run_job("clamp300", 300, 0, 0, ref_dot(300), 259);

    // Abort in ACCUM after 2 of 5 pairs, then a fresh job proves the clear.
    for (int k = 0; k < 5; k++) begin pa[k] = 8'(10 * (k + 1)); pb[k] = 8'(k + 7); end
    partial_job(5, 2);
    abort = 1'b1;
    ab_valid = 1'b1;
    #1;
    chk("abort ab_ready", 64'(ab_ready), 64'd0);
    chk("abort mac_en", 64'(mac_en), 64'd0);
    tick();
    abort = 1'b0;
    ab_valid = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort res_valid", 64'(res_valid), 64'd0);
    tick();
    chk("abort res_valid_later", 64'(res_valid), 64'd0);
    pa[0] = 8'd2; pb[0] = 8'd3; pa[1] = 8'd4; pb[1] = 8'd5;
    run_job("after_abort", 2, 0, 0, 24'd26, 5);

    // Result held under back-pressure with start pulses while busy.
    pa[0] = 8'd11; pb[0] = 8'd13; pa[1] = 8'd17; pb[1] = 8'd19; pa[2] = 8'd23; pb[2] = 8'd29;
    run_job("stall", 3, 0, 5, 24'd1133, 6);

    // Reset for one cycle mid-ACCUM.
    for (int k = 0; k < 4; k++) begin pa[k] = 8'd100; pb[k] = 8'd100; end
    partial_job(4, 2);
    rst_n = 1'b0;
    ab_valid = 1'b1;
    tick();
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst ab_ready", 64'(ab_ready), 64'd0);
    chk("midrst mac_en", 64'(mac_en), 64'd0);
    chk("midrst mac_clr", 64'(mac_clr), 64'd0);
    chk("midrst res_valid", 64'(res_valid), 64'd0);
    chk("midrst res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    ab_valid = 1'b0;
    tick();
    pa[0] = 8'd9; pb[0] = 8'd9;
    run_job("after_rst", 1, 0, 0, 24'd81, 4);

    // Randomized jobs against the reference dot product.
    for (int j = 0; j < 8; j++) begin
      int rl;
      rl = $urandom_range(0, 300);
      for (int k = 0; k < 300; k++) begin
        pa[k] = 8'($urandom);
        pb[k] = 8'($urandom);
      end
      run_job($sformatf("rand%0d", j), rl, 2, $urandom_range(0, 3), ref_dot(rl), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
